// File: rtl/dma_rd_pkg.sv
// Shared types and default sizes for the host-memory read DMA engine.
package dma_rd_pkg;

   localparam int ADDR_WIDTH_DEF  = 42;
   localparam int DATA_WIDTH_DEF  = 512;
   localparam int SIZE_WIDTH_DEF  = 32;
   localparam int MDATA_WIDTH_DEF = 16;
   localparam int FIFO_DEPTH_DEF  = 512;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_DRAIN,
      ST_DONE
   } t_dma_rd_state;

   typedef logic [ADDR_WIDTH_DEF-1:0]  t_line_addr;
   typedef logic [SIZE_WIDTH_DEF-1:0]  t_size;
   typedef logic [MDATA_WIDTH_DEF-1:0] t_mdata;

endpackage

// File: rtl/dma_rd_engine_if.sv
// c0 read channel towards MPF plus the in-order response stream towards the
// application. The engine is the master; MPF/application side is the slave.
interface dma_rd_engine_if
   import dma_rd_pkg::*;
#(
   parameter int ADDR_WIDTH  = ADDR_WIDTH_DEF,
   parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
   parameter int MDATA_WIDTH = MDATA_WIDTH_DEF
);
   logic                   c0_req_valid;
   logic [ADDR_WIDTH-1:0]  c0_req_addr;
   logic [MDATA_WIDTH-1:0] c0_req_mdata;
   logic                   c0_almost_full;
   logic                   c0_rsp_valid;
   logic [DATA_WIDTH-1:0]  c0_rsp_data;
   logic                   rd_data_valid;
   logic [DATA_WIDTH-1:0]  rd_data;
   logic                   rd_data_ready;

   modport master (
      output c0_req_valid, c0_req_addr, c0_req_mdata, rd_data_valid, rd_data,
      input  c0_almost_full, c0_rsp_valid, c0_rsp_data, rd_data_ready
   );

   modport slave (
      input  c0_req_valid, c0_req_addr, c0_req_mdata, rd_data_valid, rd_data,
      output c0_almost_full, c0_rsp_valid, c0_rsp_data, rd_data_ready
   );
endinterface

// File: rtl/dma_rd_fifo.sv
// Show-ahead response FIFO: head is visible while not empty, push and pop
// may happen in the same cycle at any occupancy.
module dma_rd_fifo #(
   parameter int DATA_WIDTH = 512,
   parameter int FIFO_DEPTH = 512
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         push_i,
   input  logic [DATA_WIDTH-1:0]        push_data_i,
   input  logic                         pop_i,
   output logic [DATA_WIDTH-1:0]        head_o,
   output logic                         empty_o,
   output logic [$clog2(FIFO_DEPTH):0]  count_o
);
   localparam int             PTR_W    = $clog2(FIFO_DEPTH);
   localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(FIFO_DEPTH);

   logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0]      wr_ptr_q;
   logic [PTR_W-1:0]      rd_ptr_q;
   logic [PTR_W:0]        count_q;
   logic                  do_push;
   logic                  do_pop;

   assign empty_o = (count_q == '0);
   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && ((count_q != FULL_CNT) || do_pop);
   assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];
   assign count_o = count_q;

   // Line storage write port.
   // NOTE: the storage array has no reset; head_o is masked while empty so stale lines never leak out.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= push_data_i;
   end

   // Pointer and occupancy bookkeeping.
   // NOTE: all sequential state uses non-blocking assignment so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         count_q <= count_q + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
      end
   end
endmodule

// File: rtl/dma_rd_engine.sv
// Read DMA engine: issues line reads for a contiguous buffer on c0, keeps
// outstanding + buffered lines within the FIFO depth, and streams responses.
module dma_rd_engine
   import dma_rd_pkg::*;
#(
   parameter int ADDR_WIDTH  = ADDR_WIDTH_DEF,
   parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
   parameter int SIZE_WIDTH  = SIZE_WIDTH_DEF,
   parameter int MDATA_WIDTH = MDATA_WIDTH_DEF,
   parameter int FIFO_DEPTH  = FIFO_DEPTH_DEF
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  go,
   input  logic [ADDR_WIDTH-1:0] start_addr,
   input  logic [SIZE_WIDTH-1:0] size,
   output logic                  busy,
   output logic                  done,
   dma_rd_engine_if.master       bus
);
   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

   t_dma_rd_state          state_q, state_d;
   logic [ADDR_WIDTH-1:0]  start_addr_q, start_addr_d;
   logic [SIZE_WIDTH-1:0]  size_q, size_d;
   logic [SIZE_WIDTH-1:0]  issued_q, issued_d;
   logic [SIZE_WIDTH-1:0]  outstanding_q, outstanding_d;
   logic [SIZE_WIDTH-1:0]  delivered_q, delivered_d;
   logic                   req_valid_q;
   logic [ADDR_WIDTH-1:0]  req_addr_q;
   logic [MDATA_WIDTH-1:0] req_mdata_q;
   logic [CNT_W-1:0]       fifo_count;
   logic                   fifo_empty;
   logic                   credit_ok;
   logic                   issue_ok;
   logic                   rsp_accept;
   logic                   pop;

   // Outstanding already includes the request registered last cycle, so the
   // sum can never exceed the buffer depth even if every response lands.
   assign credit_ok  = ({1'b0, outstanding_q} + (SIZE_WIDTH+1)'(fifo_count))
                       < (SIZE_WIDTH+1)'(FIFO_DEPTH);
   assign issue_ok   = (state_q == ST_ISSUE) && !bus.c0_almost_full
                       && (issued_q < size_q) && credit_ok;
   // Stragglers with nothing outstanding (e.g. after reset) are discarded.
   assign rsp_accept = bus.c0_rsp_valid && (outstanding_q != '0);
   assign pop        = !fifo_empty && bus.rd_data_ready;

   assign busy              = (state_q == ST_ISSUE) || (state_q == ST_DRAIN);
   assign done              = (state_q == ST_DONE);
   assign bus.c0_req_valid  = req_valid_q;
   assign bus.c0_req_addr   = req_addr_q;
   assign bus.c0_req_mdata  = req_mdata_q;
   assign bus.rd_data_valid = !fifo_empty;

   // Next-state and counter update logic.
   // NOTE: every variable gets a default first so no path leaves one unassigned and infers a latch.
   always_comb begin
      state_d       = state_q;
      start_addr_d  = start_addr_q;
      size_d        = size_q;
      issued_d      = issued_q + SIZE_WIDTH'(issue_ok);
      outstanding_d = outstanding_q + SIZE_WIDTH'(issue_ok) - SIZE_WIDTH'(rsp_accept);
      delivered_d   = delivered_q + SIZE_WIDTH'(pop);
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (go) begin
               if (size == '0) begin
                  state_d = ST_DONE;
               end else begin
                  state_d       = ST_ISSUE;
                  start_addr_d  = start_addr;
                  size_d        = size;
                  issued_d      = '0;
                  outstanding_d = '0;
                  delivered_d   = '0;
               end
            end
         end
         ST_ISSUE: begin
            if (delivered_d == size_q)   state_d = ST_DONE;
            else if (issued_d == size_q) state_d = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (delivered_d == size_q) state_d = ST_DONE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   // Transfer bookkeeping and the registered c0 request.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         start_addr_q  <= '0;
         size_q        <= '0;
         issued_q      <= '0;
         outstanding_q <= '0;
         delivered_q   <= '0;
         req_valid_q   <= 1'b0;
         req_addr_q    <= '0;
         req_mdata_q   <= '0;
      end else begin
         start_addr_q  <= start_addr_d;
         size_q        <= size_d;
         issued_q      <= issued_d;
         outstanding_q <= outstanding_d;
         delivered_q   <= delivered_d;
         req_valid_q   <= issue_ok;
         if (issue_ok) begin
            req_addr_q  <= start_addr_q + ADDR_WIDTH'(issued_q);
            req_mdata_q <= issued_q[MDATA_WIDTH-1:0];
         end
      end
   end

   dma_rd_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk         (clk),
      .rst_n       (rst_n),
      .push_i      (rsp_accept),
      .push_data_i (bus.c0_rsp_data),
      .pop_i       (pop),
      .head_o      (bus.rd_data),
      .empty_o     (fifo_empty),
      .count_o     (fifo_count)
   );
endmodule
